// File: rtl/fpu_pkg.sv
// Shared single-precision field layout, FSM states and unpack helpers for the
// truncating, denormal-flushing FPU blocks (fmul, finv).
package fpu_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {IDLE, CALC, RES} state_t;

  function automatic logic f_sign(input logic [EXP_W+MAN_W:0] v);
    return v[EXP_W+MAN_W];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [EXP_W+MAN_W:0] v);
    return v[EXP_W+MAN_W-1:MAN_W];
  endfunction

  function automatic logic [MAN_W-1:0] f_man(input logic [EXP_W+MAN_W:0] v);
    return v[MAN_W-1:0];
  endfunction
endpackage

// File: rtl/finv_if.sv
// Request/result handshake between a requester and the finv reciprocal unit.
interface finv_if;
  import fpu_pkg::*;
  logic [EXP_W+MAN_W:0] x;
  logic                 valid;
  logic                 ready;
  logic [EXP_W+MAN_W:0] y;
  logic                 done;

  modport master (output x, valid, input ready, y, done);
  modport slave  (input x, valid, output ready, y, done);
endinterface

// File: rtl/finv_div_step.sv
// One combinational restoring-division step: compare, conditionally subtract,
// shift left. The remainder stays below 2*D, so bit 24 of the difference is always 0.
module finv_div_step (
  input  logic [24:0] i_rem,
  input  logic [23:0] i_d,
  output logic [24:0] o_rem,
  output logic        o_q
);
  logic [23:0] w_diff;

  assign o_q    = (i_rem >= {1'b0, i_d});
  assign w_diff = o_q ? 24'(i_rem - {1'b0, i_d}) : i_rem[23:0];
  assign o_rem  = {w_diff, 1'b0};
endmodule

// File: rtl/finv.sv
// Iterative reciprocal: 24 restoring-division cycles produce floor(2^47/D),
// then one more cycle registers the packed result and pulses done.
module finv
  import fpu_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  finv_if.slave bus
);
  localparam logic signed [9:0] EY_BASE = 10'(2 * BIAS);

  state_t               r_state, w_next;
  logic [4:0]           r_cnt;
  logic                 r_fin;
  logic [24:0]          r_rem;
  logic [23:0]          r_d;
  logic [MAN_W-1:0]     r_q;
  logic                 r_s, r_m_zero, r_div0, r_flush;
  logic [EXP_W-1:0]     r_ey;
  logic [EXP_W+MAN_W:0] r_y;
  logic                 r_done;

  logic                 w_ready, w_accept, w_qbit;
  logic [24:0]          w_rem_nxt;
  logic [EXP_W-1:0]     w_e;
  logic [MAN_W-1:0]     w_m;
  logic                 w_m_zero;
  logic signed [9:0]    w_ey;
  logic [EXP_W+MAN_W:0] w_y;

  finv_div_step u_step (
    .i_rem (r_rem),
    .i_d   (r_d),
    .o_rem (w_rem_nxt),
    .o_q   (w_qbit)
  );

  assign w_e      = f_exp(bus.x);
  assign w_m      = f_man(bus.x);
  assign w_m_zero = (w_m == '0);
  // m == 0 gives Q = 2^24 (one binade higher), hence one more exponent step.
  assign w_ey     = EY_BASE - $signed({2'b00, w_e}) - (w_m_zero ? 10'sd0 : 10'sd1);
  assign w_accept = bus.valid & w_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = CALC;
      CALC:    if (r_fin)    w_next = RES;
      RES:     w_next = w_accept ? CALC : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b1;
    if (r_state == CALC) w_ready = 1'b0;
  end

  always_comb begin
    if (r_div0)       w_y = {r_s, EXP_MAX, {MAN_W{1'b0}}};
    else if (r_flush) w_y = {r_s, {(EXP_W+MAN_W){1'b0}}};
    else              w_y = {r_s, r_ey, r_m_zero ? {MAN_W{1'b0}} : r_q};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0; r_fin <= 1'b0; r_rem <= '0; r_d <= '0; r_q <= '0;
      r_s <= 1'b0; r_m_zero <= 1'b0; r_div0 <= 1'b0; r_flush <= 1'b0;
      r_ey <= '0; r_y <= '0; r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_cnt    <= 5'd23;
        r_fin    <= 1'b0;
        r_rem    <= 25'h100_0000;
        r_d      <= {1'b1, w_m};
        r_q      <= '0;
        r_s      <= f_sign(bus.x);
        r_m_zero <= w_m_zero;
        r_div0   <= (w_e == '0);
        r_flush  <= (w_e == EXP_MAX) || (w_ey <= 10'sd0);
        r_ey     <= w_ey[EXP_W-1:0];
      end else if (r_state == CALC) begin
        if (!r_fin) begin
          r_rem <= w_rem_nxt;
          r_q   <= {r_q[MAN_W-2:0], w_qbit};
          if (r_cnt == 5'd0) r_fin <= 1'b1;
          else               r_cnt <= r_cnt - 5'd1;
        end else begin
          r_y    <= w_y;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign bus.ready = w_ready;
  assign bus.y     = r_y;
  assign bus.done  = r_done;
endmodule

// File: tb/tb_finv.sv
// Bench for finv: directed cases, handshake timing, reset abort, and random
// operands against an arithmetic reciprocal model plus an fmul round-trip.
module tb_finv;
  logic clk;
  logic rstn;
  int   n_chk;
  int   n_pass;

  finv_if u_if ();

  finv dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_inv(input logic [31:0] xv);
    logic s;
    int e, ey;
    longint unsigned d, q;
    logic [22:0] fr;
    s = xv[31];
    e = int'(xv[30:23]);
    if (e == 0)   return {s, 8'hFF, 23'd0};
    if (e == 255) return {s, 31'd0};
    d = 64'(1) << 23;
    d = d + 64'(xv[22:0]);
    q = (64'(1) << 47) / d;
    if (q >= (64'(1) << 24)) begin fr = 23'd0; ey = 254 - e; end
    else begin fr = q[22:0]; ey = 253 - e; end
    if (ey <= 0) return {s, 31'd0};
    return {s, 8'(ey), fr};
  endfunction

  function automatic logic [31:0] ref_fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] f;
    logic s;
    int e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin f = p[46:24]; e++; end
    else f = p[45:23];
    if (e <= 0)   return {s, 31'd0};
    if (e >= 255) return {s, 8'hFF, 23'd0};
    return {s, 8'(e), f};
  endfunction

  // Accept one request, then wait (bounded) for done; ready must stay low meanwhile.
  task automatic run_req(input logic [31:0] xv, output logic [31:0] yv,
                         output int lat, output bit rdy_ok);
    int k;
    @(negedge clk);
    k = 0;
    while (!u_if.ready && k < 50) begin @(negedge clk); k++; end
    u_if.x = xv;
    u_if.valid = 1'b1;
    @(posedge clk); #1;
    u_if.valid = 1'b0;
    lat = -1;
    rdy_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (u_if.done) begin lat = c; break; end
      if (u_if.ready) rdy_ok = 1'b0;
    end
    yv = u_if.y;
  endtask

  logic [31:0] dx [8] = '{32'h40400000, 32'h3FC00000, 32'hC0800000, 32'h40000000,
                          32'h00000000, 32'h80001234, 32'h7F000000, 32'h7F7FFFFF};
  logic [31:0] dy [8] = '{32'h3EAAAAAA, 32'h3F2AAAAA, 32'hBE800000, 32'h3F000000,
                          32'h7F800000, 32'hFF800000, 32'h00000000, 32'h00000000};

  initial begin
    logic [31:0] yv, y1, y2, xv, fm;
    int lat, d1, d2, nd;
    bit rdy_ok;
    n_chk = 0;
    n_pass = 0;
    u_if.x = '0;
    u_if.valid = 1'b0;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", u_if.y, 32'h0);
    chk("rst_done", {31'd0, u_if.done}, 32'd1 - 32'd1);
    chk("rst_ready", {31'd0, u_if.ready}, 32'd1);
    @(negedge clk) rstn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_req(dx[i], yv, lat, rdy_ok);
      chk($sformatf("dir_y_%08h", dx[i]), yv, dy[i]);
      chk("dir_lat", 32'(lat), 32'd25);
      chk("dir_rdy_low", {31'd0, rdy_ok}, 32'd1);
      @(posedge clk); #1;
      chk("dir_done_pulse", {31'd0, u_if.done}, 32'd0);
    end

    // Back-to-back with valid held high: 2.0 then 3.0.
    @(negedge clk);
    u_if.x = 32'h40000000;
    u_if.valid = 1'b1;
    @(posedge clk); #1;
    u_if.x = 32'h40400000;
    d1 = -1; d2 = -1; nd = 0; y1 = '0; y2 = '0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (u_if.done) begin
        nd++;
        if (nd == 1) begin d1 = c; y1 = u_if.y; end
        else if (nd == 2) begin d2 = c; y2 = u_if.y; u_if.valid = 1'b0; end
      end
    end
    u_if.valid = 1'b0;
    chk("b2b_d1", 32'(d1), 32'd25);
    chk("b2b_d2", 32'(d2), 32'd51);
    chk("b2b_y1", y1, 32'h3F000000);
    chk("b2b_y2", y2, 32'h3EAAAAAA);
    chk("b2b_ndone", 32'(nd), 32'd2);

    // A valid pulse during CALC must be ignored.
    @(negedge clk);
    u_if.x = 32'h3FC00000;
    u_if.valid = 1'b1;
    @(posedge clk); #1;
    u_if.valid = 1'b0;
    d1 = -1; nd = 0; y1 = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 5) begin u_if.x = 32'h40000000; u_if.valid = 1'b1; end
      if (c == 6) u_if.valid = 1'b0;
      @(posedge clk); #1;
      if (u_if.done) begin nd++; if (nd == 1) begin d1 = c; y1 = u_if.y; end end
    end
    chk("ign_ndone", 32'(nd), 32'd1);
    chk("ign_lat", 32'(d1), 32'd25);
    chk("ign_y", y1, 32'h3F2AAAAA);

    // Reset in the middle of a computation.
    @(negedge clk);
    u_if.x = 32'h40400000;
    u_if.valid = 1'b1;
    @(posedge clk); #1;
    u_if.valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_y", u_if.y, 32'h0);
    chk("mid_rst_done", {31'd0, u_if.done}, 32'd0);
    chk("mid_rst_ready", {31'd0, u_if.ready}, 32'd1);
    @(negedge clk) rstn = 1'b1;
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (u_if.done) nd++;
    end
    chk("mid_rst_nodone", 32'(nd), 32'd0);
    run_req(32'h40400000, yv, lat, rdy_ok);
    chk("post_rst_y", yv, 32'h3EAAAAAA);
    chk("post_rst_lat", 32'(lat), 32'd25);

    // Fully random bit patterns, including zero/max exponents.
    for (int i = 0; i < 40; i++) begin
      xv = $urandom;
      if (i % 8 == 0) xv[30:23] = 8'd0;
      if (i % 8 == 1) xv[30:23] = 8'hFF;
      if (i % 8 == 2) xv[30:23] = 8'(253 + (i % 2));
      run_req(xv, yv, lat, rdy_ok);
      chk($sformatf("rnd_y_%08h", xv), yv, ref_inv(xv));
      chk("rnd_lat", 32'(lat), 32'd25);
    end

    // Random normals whose reciprocal is normal: fmul(x, y) must land near 1.0.
    for (int i = 0; i < 40; i++) begin
      xv = {1'($urandom), 8'($urandom_range(1, 252)), 23'($urandom)};
      if (i % 10 == 0) xv[22:0] = 23'd0;
      run_req(xv, yv, lat, rdy_ok);
      chk($sformatf("nrm_y_%08h", xv), yv, ref_inv(xv));
      fm = ref_fmul(xv, yv);
      chk($sformatf("fmul_one_%08h", fm), {31'd0, (fm <= 32'h3F800000 && fm >= 32'h3F7FFFFC)}, 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
